regfile_dump_controller: RTL and testbench

REGFILE_DUMP_CONTROLLER -- requirements
Module: regfile_dump_controller

---
 rtl/regfile_dump_controller_if.sv | 39 +++
 rtl/regfile_dump_controller.sv | 133 +++++++++++++
 tb/tb_regfile_dump_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_controller_if.sv
// Purpose: bundles the dump controller's request, register-file read port and
// stream/status signals into one interface.
// Ports (signals):
//   start, first_reg[4:0], last_reg[4:0]  - dump request (driven by master)
//   rf_read_register[4:0], rf_read_data   - register file read port
//   dump_data[31:0], dump_index[4:0]      - captured beat payload
//   dump_valid / dump_ready               - stream handshake
//   busy, done, error, checksum[31:0]     - status
// Modports: master = requester / register file / sink side, slave = controller.
interface regfile_dump_controller_if;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic              start;
  logic [IDX_W-1:0]  first_reg;
  logic [IDX_W-1:0]  last_reg;
  logic [IDX_W-1:0]  rf_read_register;
  logic [DATA_W-1:0] rf_read_data;
  logic [DATA_W-1:0] dump_data;
  logic [IDX_W-1:0]  dump_index;
  logic              dump_valid;
  logic              dump_ready;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  modport master (
    output start, first_reg, last_reg, rf_read_data, dump_ready,
    input  rf_read_register, dump_data, dump_index, dump_valid,
           busy, done, error, checksum
  );

  modport slave (
    input  start, first_reg, last_reg, rf_read_data, dump_ready,
    output rf_read_register, dump_data, dump_index, dump_valid,
           busy, done, error, checksum
  );
endinterface

// File: rtl/regfile_dump_controller.sv
// Purpose: streams register file entries first_reg..last_reg out over a
// valid/ready handshake, one beat per read, keeping a running XOR checksum.
// Ports:
//   clk  - system clock, posedge
//   rst  - asynchronous active-high reset
//   bus  - regfile_dump_controller_if.slave (request, rf read port, stream, status)
// The register file is only ever read; rf_read_data is combinational from
// rf_read_register and is captured in READ.
module regfile_dump_controller (
  input  logic                       clk,
  input  logic                       rst,
  regfile_dump_controller_if.slave   bus
);
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      index_q <= index_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    index_d = index_q;
    data_d  = data_q;
    csum_d  = csum_q;
    valid_d = valid_q;
    error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.first_reg <= bus.last_reg) begin
            ptr_d   = bus.first_reg;
            last_d  = bus.last_reg;
            addr_d  = bus.first_reg;
            csum_d  = '0;
            state_d = READ;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      READ: begin
        data_d  = bus.rf_read_data;
        index_d = ptr_q;
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (bus.dump_ready) begin
          csum_d  = csum_q ^ data_q;
          valid_d = 1'b0;
          // Equality test ends the dump, so ptr never has to wrap past 31.
          if (ptr_q == last_q) begin
            addr_d  = '0;
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + IDX_W'(1);
            addr_d  = ptr_q + IDX_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags registered against the state being entered
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.rf_read_register = addr_q;
  assign bus.dump_data        = data_q;
  assign bus.dump_index       = index_q;
  assign bus.dump_valid       = valid_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.checksum         = csum_q;
endmodule

// File: tb/tb_regfile_dump_controller.sv
// Purpose: directed self-checking bench for regfile_dump_controller with a
// register file model, an expected-beat queue and a negedge stream monitor.
module tb_regfile_dump_controller;
  logic clk;
  logic rst;
  regfile_dump_controller_if bus ();

  regfile_dump_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] regs [32];
  assign bus.rf_read_data = regs[bus.rf_read_register];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int beat_cnt = 0;
  logic [36:0] exp_q [$];
  logic [36:0] exp_e;
  logic [31:0] exp_csum;
  logic        held_valid = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_index;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stream monitor: pops expected beats on transfers, checks stall stability
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done)  done_cnt++;
      if (bus.error) err_cnt++;
      if (bus.dump_valid) begin
        if (held_valid) begin
          check("stall_data", bus.dump_data, held_data);
          check("stall_index", 32'(bus.dump_index), 32'(held_index));
        end
        if (bus.dump_ready) begin
          beat_cnt++;
          held_valid = 1'b0;
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat got=%h exp=none", bus.dump_data);
          end
          if (exp_q.size() != 0) begin
            exp_e = exp_q.pop_front();
            check("beat_index", 32'(bus.dump_index), 32'(exp_e[36:32]));
            check("beat_data", bus.dump_data, exp_e[31:0]);
          end
        end else begin
          held_valid = 1'b1;
          held_data  = bus.dump_data;
          held_index = bus.dump_index;
        end
      end else begin
        held_valid = 1'b0;
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  // mode 0: ready held 1; mode 1: ready toggles; mode 2: ready 1, start re-asserted every cycle
  task automatic do_dump(input string tag, input logic [4:0] f, input logic [4:0] l, input int mode);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    exp_csum = '0;
    for (int i = int'(f); i <= int'(l); i++) begin
      exp_q.push_back({5'(i), regs[i]});
      exp_csum = exp_csum ^ regs[i];
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.first_reg = f;
    bus.last_reg = l;
    bus.dump_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (c == 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (mode == 1) bus.dump_ready = ~bus.dump_ready;
      bus.start = (mode == 2);
    end
    bus.start = 1'b0;
    bus.dump_ready = 1'b1;
    check({tag, "_timeout"}, 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_checksum"}, bus.checksum, exp_csum);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int e0;
    int b0;
    bit seen;
    for (int i = 0; i < 32; i++) regs[i] = 32'((i % 16) * 32'h1111);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.first_reg = '0;
    bus.last_reg = '0;
    bus.dump_ready = 1'b0;
    #12;
    check("rst_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_data", bus.dump_data, 32'd0);
    check("rst_index", 32'(bus.dump_index), 32'd0);
    check("rst_checksum", bus.checksum, 32'd0);
    check("rst_rfaddr", 32'(bus.rf_read_register), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_dump("full", 5'd0, 5'd31, 0);
    check("full_csum_const", bus.checksum, 32'h0000_0000);

    do_dump("toggle", 5'd1, 5'd4, 1);
    check("toggle_csum_const", bus.checksum, 32'h0000_4444);

    regs[8] = 32'ha5a5_a5a5;
    do_dump("single", 5'd8, 5'd8, 0);
    check("single_csum_const", bus.checksum, 32'ha5a5_a5a5);

    // Range error: first > last
    e0 = err_cnt;
    b0 = beat_cnt;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.first_reg = 5'd9;
    bus.last_reg = 5'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("err_pulse", 32'(bus.error), 32'd1);
    check("err_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("err_clear", 32'(bus.error), 32'd0);
    check("err_novalid", 32'(bus.dump_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("err_count", 32'(err_cnt - e0), 32'd1);
    check("err_nobeat", 32'(beat_cnt - b0), 32'd0);
    check("err_checksum_kept", bus.checksum, 32'ha5a5_a5a5);

    do_dump("restart", 5'd0, 5'd3, 2);

    // Reset while stalled in SEND on index 5
    bus.dump_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.first_reg = 5'd5;
    bus.last_reg = 5'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.dump_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rst_mid_reach", 32'(seen), 32'd1);
    check("rst_mid_index", 32'(bus.dump_index), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_data", bus.dump_data, 32'd0);
    check("rst_mid_index0", 32'(bus.dump_index), 32'd0);
    check("rst_mid_checksum", bus.checksum, 32'd0);
    check("rst_mid_rfaddr", 32'(bus.rf_read_register), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    b0 = beat_cnt;
    do_dump("post_rst", 5'd0, 5'd1, 0);
    check("post_rst_beats", 32'(beat_cnt - b0), 32'd2);
    check("post_rst_csum_const", bus.checksum, 32'h0000_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
